// File: rtl/hicore_flush_fifo_pkg.sv
// hicore_pkg: shared constants and elaboration helpers for the hicore pipeline
package hicore_pkg;
  localparam int HICORE_XLEN = 32;
  localparam int HICORE_IFQ_DP = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/hicore_flush_fifo_if.sv
// hicore_flush_fifo_if: producer and consumer valid/ready buses of the flush FIFO
interface hicore_flush_fifo_if #(parameter int DW = 32);
  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;
  modport slave (input i_vld, i_dat, o_rdy, output i_rdy, o_vld, o_dat);
  modport master (output i_vld, i_dat, o_rdy, input i_rdy, o_vld, o_dat);
endinterface

// File: rtl/hicore_fifo_ptr.sv
// hicore_fifo_ptr: wrap-bit pointers, registered occupancy and status flags with flush
module hicore_fifo_ptr
  import hicore_pkg::*;
#(
  parameter int DP       = HICORE_IFQ_DP,
  parameter int AFULL_TH = DP - 1,
  localparam int AW      = clog2(DP),
  localparam int PTR_W   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wen,
  input  logic             ren,
  output logic [AW-1:0]    wr_addr,
  output logic [AW-1:0]    rd_addr,
  output logic [PTR_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             afull
);
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  if (DP < 2 || (DP & (DP - 1)) != 0 || AFULL_TH < 1 || AFULL_TH > DP) begin : g_bad_param
    $error("hicore_fifo_ptr: DP must be a power of two >= 2 and AFULL_TH within 1..DP");
  end
  // next pointers and occupancy; flush wins over any transfer
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + PTR_W'(wen);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PTR_W'(ren);
    count_d  = flush ? '0 : count_q + PTR_W'(wen & ~ren) - PTR_W'(ren & ~wen);
  end
  // pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  assign wr_addr = wr_ptr_q[AW-1:0];
  assign rd_addr = rd_ptr_q[AW-1:0];
  assign count   = count_q;
  assign empty   = wr_ptr_q == rd_ptr_q;
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_addr == rd_addr);
  assign afull   = count_q >= PTR_W'(AFULL_TH);
endmodule

// File: rtl/hicore_flush_fifo.sv
// hicore_flush_fifo: valid/ready FIFO with empty bypass, optional ready cut, afull and flush
module hicore_flush_fifo
  import hicore_pkg::*;
#(
  parameter int DP        = HICORE_IFQ_DP,
  parameter int DW        = HICORE_XLEN,
  parameter int BYPASS    = 1,
  parameter int CUT_READY = 0,
  parameter int AFULL_TH  = DP - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hicore_flush_fifo_if.slave   bus,
  input  logic                 flush,
  output logic [clog2(DP):0]   count,
  output logic                 afull
);
  localparam int AW = clog2(DP);
  localparam bit BYP_EN = BYPASS != 0;
  localparam bit CUT_EN = CUT_READY != 0;
  logic [DW-1:0] mem_q [DP];
  logic [AW-1:0] wr_addr, rd_addr;
  logic          empty, full, byp, wen, ren;
  hicore_fifo_ptr #(.DP(DP), .AFULL_TH(AFULL_TH)) u_ptr (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wen(wen), .ren(ren),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .count(count),
    .empty(empty), .full(full), .afull(afull)
  );
  // handshake qualification, bypass selection and output mux
  always_comb begin
    byp       = BYP_EN && empty && bus.i_vld && bus.o_rdy && !flush;
    bus.i_rdy = CUT_EN ? (!full && !flush) : ((!full || bus.o_rdy) && !flush);
    wen       = bus.i_vld && bus.i_rdy && !byp;
    ren       = !empty && bus.o_rdy && !flush;
    bus.o_vld = !flush && (!empty || (BYP_EN && bus.i_vld));
    bus.o_dat = empty ? bus.i_dat : mem_q[rd_addr];
  end
  // storage write; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wen) mem_q[wr_addr] <= bus.i_dat;
  end
endmodule

// File: tb/tb_hicore_flush_fifo.sv
// tb_hicore_flush_fifo: directed checks of fill/drain, bypass, full read+write, flush, wrap and async reset
module tb_hicore_flush_fifo;
  logic clk = 1'b0;
  logic rst_n;
  logic f0, f1, af0, af1;
  logic [2:0] cnt0, cnt1;
  int errors = 0;
  int checks = 0;
  hicore_flush_fifo_if #(.DW(32)) b0 ();
  hicore_flush_fifo_if #(.DW(32)) b1 ();
  hicore_flush_fifo #(.DP(4), .DW(32), .BYPASS(0), .CUT_READY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .flush(f0), .count(cnt0), .afull(af0)
  );
  hicore_flush_fifo #(.DP(4), .DW(32), .BYPASS(1), .CUT_READY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .flush(f1), .count(cnt1), .afull(af1)
  );
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    f0 = 0; f1 = 0;
    b0.i_vld = 0; b0.i_dat = '0; b0.o_rdy = 0;
    b1.i_vld = 1; b1.i_dat = 32'h77; b1.o_rdy = 0;
    #1;
    checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
    checks++; if (b0.o_vld !== 1'b0) begin errors++; $display("FAIL reset_ovld0 got=%b exp=0", b0.o_vld); end
    checks++; if (b0.i_rdy !== 1'b1) begin errors++; $display("FAIL reset_irdy0 got=%b exp=1", b0.i_rdy); end
    checks++; if (af0 !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b exp=0", af0); end
    checks++; if (b1.o_vld !== 1'b1) begin errors++; $display("FAIL reset_byp_ovld got=%b exp=1", b1.o_vld); end
    f1 = 1;
    #1;
    checks++; if (b1.o_vld !== 1'b0) begin errors++; $display("FAIL reset_byp_flush_ovld got=%b exp=0", b1.o_vld); end
    f1 = 0; b1.i_vld = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_fill_drain;
    for (int k = 0; k < 4; k++) begin
      b0.i_vld = 1; b0.i_dat = 32'hA0 + k;
      #1;
      checks++; if (b0.i_rdy !== 1'b1) begin errors++; $display("FAIL fill_irdy k=%0d got=%b exp=1", k, b0.i_rdy); end
      tick;
      checks++; if (cnt0 !== 3'(k + 1)) begin errors++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, cnt0, k + 1); end
      checks++; if (af0 !== (k + 1 >= 3)) begin errors++; $display("FAIL fill_afull k=%0d got=%b exp=%b", k, af0, k + 1 >= 3); end
    end
    #1;
    checks++; if (b0.i_rdy !== 1'b0) begin errors++; $display("FAIL full_irdy got=%b exp=0", b0.i_rdy); end
    b0.i_vld = 0; b0.o_rdy = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (b0.o_vld !== 1'b1) begin errors++; $display("FAIL drain_ovld k=%0d got=%b exp=1", k, b0.o_vld); end
      checks++; if (b0.o_dat !== 32'hA0 + k) begin errors++; $display("FAIL drain_data k=%0d got=%0h exp=%0h", k, b0.o_dat, 32'hA0 + k); end
      tick;
    end
    checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", cnt0); end
    checks++; if (b0.o_vld !== 1'b0) begin errors++; $display("FAIL drain_empty_ovld got=%b exp=0", b0.o_vld); end
    b0.o_rdy = 0;
  endtask

  task automatic test_bypass;
    b1.i_vld = 1; b1.o_rdy = 1; b1.i_dat = 32'h55;
    #1;
    checks++; if (b1.o_vld !== 1'b1) begin errors++; $display("FAIL byp_ovld got=%b exp=1", b1.o_vld); end
    checks++; if (b1.o_dat !== 32'h55) begin errors++; $display("FAIL byp_data got=%0h exp=55", b1.o_dat); end
    tick;
    checks++; if (cnt1 !== 3'd0) begin errors++; $display("FAIL byp_count got=%0d exp=0", cnt1); end
    b1.i_vld = 0;
    #1;
    checks++; if (b1.o_vld !== 1'b0) begin errors++; $display("FAIL byp_after_ovld got=%b exp=0", b1.o_vld); end
    b1.o_rdy = 0;
  endtask

  task automatic test_full_rw;
    for (int k = 0; k < 4; k++) begin
      b0.i_vld = 1; b0.i_dat = 32'h10 + k;
      tick;
    end
    b0.i_dat = 32'h14; b0.o_rdy = 1;
    #1;
    checks++; if (b0.i_rdy !== 1'b1) begin errors++; $display("FAIL fullrw_irdy got=%b exp=1", b0.i_rdy); end
    checks++; if (b0.o_dat !== 32'h10) begin errors++; $display("FAIL fullrw_head got=%0h exp=10", b0.o_dat); end
    tick;
    checks++; if (cnt0 !== 3'd4) begin errors++; $display("FAIL fullrw_count got=%0d exp=4", cnt0); end
    b0.i_vld = 0;
    for (int k = 1; k < 5; k++) begin
      #1;
      checks++; if (b0.o_dat !== 32'h10 + k) begin errors++; $display("FAIL fullrw_drain k=%0d got=%0h exp=%0h", k, b0.o_dat, 32'h10 + k); end
      tick;
    end
    checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL fullrw_end_count got=%0d exp=0", cnt0); end
    b0.o_rdy = 0;
  endtask

  task automatic test_cut_ready;
    for (int k = 0; k < 4; k++) begin
      b1.i_vld = 1; b1.i_dat = 32'hC0 + k;
      tick;
    end
    checks++; if (cnt1 !== 3'd4) begin errors++; $display("FAIL cut_count got=%0d exp=4", cnt1); end
    checks++; if (af1 !== 1'b1) begin errors++; $display("FAIL cut_afull got=%b exp=1", af1); end
    b1.o_rdy = 1;
    #1;
    checks++; if (b1.i_rdy !== 1'b0) begin errors++; $display("FAIL cut_irdy got=%b exp=0", b1.i_rdy); end
    checks++; if (b1.o_dat !== 32'hC0) begin errors++; $display("FAIL cut_head got=%0h exp=c0", b1.o_dat); end
    tick;
    checks++; if (cnt1 !== 3'd3) begin errors++; $display("FAIL cut_pop_count got=%0d exp=3", cnt1); end
    b1.i_vld = 0; b1.o_rdy = 0; f1 = 1;
    tick;
    f1 = 0;
    checks++; if (cnt1 !== 3'd0) begin errors++; $display("FAIL cut_flush_count got=%0d exp=0", cnt1); end
  endtask

  task automatic test_flush;
    for (int k = 0; k < 4; k++) begin
      b0.i_vld = 1; b0.i_dat = 32'h20 + k;
      tick;
    end
    f0 = 1; b0.i_dat = 32'h24; b0.o_rdy = 1;
    #1;
    checks++; if (b0.i_rdy !== 1'b0) begin errors++; $display("FAIL flush_irdy got=%b exp=0", b0.i_rdy); end
    checks++; if (b0.o_vld !== 1'b0) begin errors++; $display("FAIL flush_ovld got=%b exp=0", b0.o_vld); end
    tick;
    f0 = 0; b0.i_vld = 0;
    checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", cnt0); end
    tick;
    checks++; if (b0.o_vld !== 1'b0) begin errors++; $display("FAIL flush_no_deliver got=%b exp=0", b0.o_vld); end
    b0.o_rdy = 0; b0.i_vld = 1;
    tick;
    tick;
    b0.i_vld = 0; f0 = 1;
    tick;
    checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL flush2a_count got=%0d exp=0", cnt0); end
    tick;
    checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL flush2b_count got=%0d exp=0", cnt0); end
    f0 = 0;
  endtask

  task automatic test_stream;
    int mc, tx, rx;
    bit exp_rdy, hs_in, hs_out;
    mc = 0; tx = 0; rx = 0;
    for (int c = 0; c < 60 && rx < 10; c++) begin
      b0.i_vld = tx < 10; b0.i_dat = tx; b0.o_rdy = (c % 2 == 0);
      #1;
      exp_rdy = (mc < 4) || b0.o_rdy;
      checks++; if (b0.i_rdy !== exp_rdy) begin errors++; $display("FAIL stream_irdy c=%0d got=%b exp=%b", c, b0.i_rdy, exp_rdy); end
      checks++; if (b0.o_vld !== (mc > 0)) begin errors++; $display("FAIL stream_ovld c=%0d got=%b exp=%b", c, b0.o_vld, mc > 0); end
      hs_in = b0.i_vld && exp_rdy;
      hs_out = (mc > 0) && b0.o_rdy;
      if (hs_out) begin
        checks++; if (b0.o_dat !== 32'(rx)) begin errors++; $display("FAIL stream_data got=%0d exp=%0d", b0.o_dat, rx); end
        rx++;
      end
      if (hs_in) tx++;
      mc = mc + int'(hs_in) - int'(hs_out);
      tick;
      checks++; if (cnt0 !== 3'(mc) || mc > 4) begin errors++; $display("FAIL stream_count c=%0d got=%0d exp=%0d", c, cnt0, mc); end
    end
    checks++; if (rx !== 10) begin errors++; $display("FAIL stream_timeout delivered=%0d exp=10", rx); end
    b0.i_vld = 0; b0.o_rdy = 0;
  endtask

  task automatic test_async_reset;
    for (int k = 0; k < 3; k++) begin
      b0.i_vld = 1; b0.i_dat = 32'h30 + k;
      tick;
    end
    b0.i_vld = 0;
    checks++; if (cnt0 !== 3'd3) begin errors++; $display("FAIL areset_pre_count got=%0d exp=3", cnt0); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", cnt0); end
    checks++; if (b0.o_vld !== 1'b0) begin errors++; $display("FAIL areset_ovld got=%b exp=0", b0.o_vld); end
    checks++; if (af0 !== 1'b0) begin errors++; $display("FAIL areset_afull got=%b exp=0", af0); end
    #1;
    rst_n = 1'b1;
    tick;
    checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL areset_post_count got=%0d exp=0", cnt0); end
    checks++; if (b0.o_vld !== 1'b0) begin errors++; $display("FAIL areset_post_ovld got=%b exp=0", b0.o_vld); end
  endtask

  initial begin
    test_reset;
    test_fill_drain;
    test_bypass;
    test_full_rw;
    test_cut_ready;
    test_flush;
    test_stream;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hicore_flush_fifo.md
Name: hicore_flush_fifo

Overview:
Parametrised synchronous valid/ready FIFO. It is the next-generation buffer for the fetch/decode path. It adds, in one block:
- configurable depth with a registered occupancy count;
- optional same-cycle bypass when empty;
- optional ready cutting;
- an almost-full flag;
- a single-cycle flush that discards all buffered entries on branch/redirect.

It sits between the IFU and decode, and wherever a skid buffer must be killed on a pipeline redirect.

Parameters:
- DP, 4: number of storage entries; power of two, DP >= 2.
- DW, 32: payload width in bits.
- BYPASS, 1: 1 = when empty, input may pass to output in the same cycle; 0 = minimum latency of one cycle.
- CUT_READY, 0: 1 = i_rdy depends only on registered state (~full); 0 = i_rdy also asserts when full and o_rdy is high.
- AFULL_TH, DP-1: occupancy at or above which afull asserts; legal range 1..DP.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_vld  input  1  producer valid.
- i_rdy  output  1  FIFO ready to accept.
- i_dat  input  DW  producer payload.
- o_vld  output  1  consumer valid.
- o_rdy  input  1  consumer ready.
- o_dat  output  DW  consumer payload.
- flush  input  1  synchronous discard of all entries; highest priority.
- count  output  $clog2(DP)+1  registered number of stored entries, 0..DP.
- afull  output  1  count >= AFULL_TH.

Behaviour:
- Reset (async, rst_n low):
  - wr_ptr, rd_ptr and count reset to 0; afull = 0 (AFULL_TH >= 1).
  - o_vld = 0 when BYPASS=0; when BYPASS=1, o_vld follows i_vld, which is still gated by flush.
  - i_rdy = 1.
  - Storage array is not reset.
  - Reset released mid-transfer: no entry survives, and no handshake is reported for the reset cycle.
- Pointers:
  - Width PTR_W = $clog2(DP)+1; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low bits are equal.
  - Pointers increment modulo 2^PTR_W; wrap from DP-1 to 0 in the low bits toggles the MSB.
- Handshakes:
  - A transfer occurs only on vld & rdy at the same edge.
  - Once accepted, data is never dropped except by flush.
- Bypass fire: byp = BYPASS & empty & i_vld & o_rdy & ~flush.
  - The input goes straight to the output; nothing is written and the pointers are unchanged.
- Write and read enables:
  - wen = i_vld & i_rdy & ~byp.
  - ren = ~empty & o_rdy & ~flush.
- Output:
  - o_vld = ~flush & (~empty | (BYPASS & i_vld)).
  - o_dat = empty ? i_dat : mem[rd_ptr low bits].
  - o_dat is don't-care when o_vld = 0.
- Input ready:
  - CUT_READY=1: i_rdy = ~full & ~flush.
  - CUT_READY=0: i_rdy = (~full | o_rdy) & ~flush. When full, a simultaneous read and write keeps count = DP.
- Count update:
  - +1 on wen & ~ren; -1 on ren & ~wen; unchanged when both or neither fire.
  - Never exceeds DP and never underflows.
- Flush:
  - Pointers and count go to 0 at the next edge.
  - i_rdy and o_vld are forced low in the flush cycle, so no handshake completes and no data is lost silently.
  - A flush asserted while full, empty or mid-burst behaves identically.
  - Back-to-back flush cycles hold the FIFO empty.
- Latency:
  - BYPASS=0: data written at edge N is visible with o_vld at cycle N+1.
  - BYPASS=1 and empty: 0 cycles.
- Throughput: one transfer per cycle sustained in all modes; with CUT_READY=1, throughput holds only while not full.
- afull: combinational compare of registered count; glitch-free relative to clk.
- Elaboration errors: DP not a power of two, DP < 2, or AFULL_TH outside 1..DP.

Decomposition:
- Shared package hicore_pkg holds:
  - function clog2;
  - localparam HICORE_XLEN = 32;
  - default FIFO depth constant HICORE_IFQ_DP = 4.
- One natural sub-module, hicore_fifo_ptr: pointer/count/full/empty/afull logic with flush, parametrised by DP and AFULL_TH. The top level holds the storage array, bypass mux and ready logic.

Test Plan:
1. DP=4, BYPASS=0, o_rdy=0: push 0xA0..0xA3 on consecutive cycles. Expect count 1,2,3,4, afull at count 3, i_rdy=0 at count 4. Then o_rdy=1: outputs 0xA0..0xA3 in order, count returns to 0.
2. BYPASS=1, empty, i_vld=o_rdy=1, i_dat=0x55. Expect o_vld=1 and o_dat=0x55 in the same cycle, count stays 0, pointers unchanged.
3. CUT_READY=0, full with 0x10..0x13, i_vld=o_rdy=1, i_dat=0x14. Expect i_rdy=1, 0x10 popped, count stays 4, next head 0x11, 0x14 at tail.
4. Full FIFO, flush=1 for one cycle with i_vld=o_rdy=1. Expect i_rdy=0 and o_vld=0 that cycle, count=0 next cycle, no entry delivered afterward.
5. Stream 10 items through DP=4 with o_rdy toggling 1,0,1,0. Expect ordered delivery 0..9 across pointer wrap, count never > 4.
6. Assert rst_n=0 asynchronously mid-cycle with count=3. Expect count=0 and o_vld=0 (BYPASS=0) immediately, before the next clk edge.
